// File: rtl/led_matrix_pwm.sv
// ----------------------------------------------------------------------------
// led_matrix_pwm
//
// Scans a ROWS x COLS LED matrix one cathode row at a time. Each LED has a
// BITS-bit brightness. Each row starts with BLANK clocks of all-off anti-ghost
// time. That is followed by 2**BITS-1 PWM steps of DWELL clocks each. In step s
// an LED is lit when its brightness is greater than s.
//
// Brightness is double-buffered. Writes always land in the back buffer and
// the scanner reads only the front buffer. A requested swap is held pending
// and commits on the clock edge where the scanner wraps into row-0 blanking.
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   wr_en        write strobe (one write per cycle)
//   wr_addr      LED index = row*COLS + col; out-of-range indices are ignored
//   wr_data      brightness for wr_addr
//   swap_req     request a front/back swap at the next frame boundary
//   aled         anode drive, active low (0 = column lit)
//   kled_tri     cathode output enable, one-hot row select, 0 = all off
//   frame_start  1-cycle pulse on the first clock of row-0 blanking
//   swap_done    1-cycle pulse, coincident with frame_start, when a swap took
// ----------------------------------------------------------------------------
module led_matrix_pwm #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int BITS  = 4,
    parameter int DWELL = 64,
    parameter int BLANK = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en,
    input  logic [$clog2(ROWS*COLS)-1:0]   wr_addr,
    input  logic [BITS-1:0]                wr_data,
    input  logic                           swap_req,
    output logic [COLS-1:0]                aled,
    output logic [ROWS-1:0]                kled_tri,
    output logic                           frame_start,
    output logic                           swap_done
);

    localparam int N     = ROWS * COLS;
    localparam int AW    = $clog2(N);
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int STEPS = (2 ** BITS) - 1;
    localparam int CMAX  = (BLANK > DWELL) ? BLANK : DWELL;
    localparam int CW    = ($clog2(CMAX) > 0) ? $clog2(CMAX) : 1;
    localparam logic [AW:0] N_LIM = N[AW:0];

    typedef enum logic {
        ST_BLANK,
        ST_DRIVE
    } state_t;

    state_t              state_q, state_d;
    logic [RW-1:0]       row_q, row_d;
    logic [BITS-1:0]     step_q, step_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                pending_q, pending_d;
    logic                front_sel_q, front_sel_d;
    logic                swapped_q, swapped_d;
    logic [BITS-1:0]     mem_q [2][N];
    logic [BITS-1:0]     mem_d [2][N];
    logic [COLS-1:0]     aled_q, aled_d;
    logic [ROWS-1:0]     kled_q, kled_d;
    logic                frame_start_q, frame_start_d;
    logic                swap_done_q, swap_done_d;

    logic                wr_in_range;
    logic                frame_end;
    logic                commit;
    logic [COLS-1:0]     col_lit;

    // With a non power-of-two LED count some addresses on the port map to
    // nothing; with a power-of-two count every address is valid.
    generate
        if ((2 ** AW) > N) begin : g_range_check
            assign wr_in_range = ({1'b0, wr_addr} < N_LIM);
        end else begin : g_range_full
            assign wr_in_range = 1'b1;
        end
    endgenerate

    // Last clock of the last PWM step of the last row: the next edge wraps
    // into row-0 blanking, so a pending swap commits on that same edge.
    assign frame_end = (state_q == ST_DRIVE) && (cnt_q == CW'(DWELL - 1))
                    && (step_q == BITS'(STEPS - 1)) && (row_q == RW'(ROWS - 1));
    assign commit    = frame_end && pending_q;

    // Per-column PWM compare against the front buffer for the current row.
    generate
        for (genvar gi = 0; gi < COLS; gi++) begin : g_col
            logic [AW-1:0] idx;
            assign idx        = AW'(row_q * COLS + gi);
            assign col_lit[gi] = (state_q == ST_DRIVE) && (mem_q[front_sel_q][idx] > step_q);
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        step_d  = step_q;
        cnt_d   = cnt_q + 1'b1;

        case (state_q)
            ST_BLANK: begin
                if (cnt_q == CW'(BLANK - 1)) begin
                    state_d = ST_DRIVE;
                    cnt_d   = '0;
                    step_d  = '0;
                end
            end
            default: begin
                if (cnt_q == CW'(DWELL - 1)) begin
                    cnt_d = '0;
                    if (step_q == BITS'(STEPS - 1)) begin
                        state_d = ST_BLANK;
                        step_d  = '0;
                        row_d   = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
        endcase

        // A request arriving in the commit cycle starts a fresh pending swap.
        pending_d   = commit ? swap_req : (pending_q | swap_req);
        front_sel_d = front_sel_q ^ commit;
        swapped_d   = commit;

        // The write uses the pre-swap back buffer, so a write in the commit
        // cycle becomes visible in the frame that is just starting.
        mem_d = mem_q;
        if (wr_en && wr_in_range) begin
            mem_d[~front_sel_q][wr_addr] = wr_data;
        end

        aled_d        = ~col_lit;
        kled_d        = (state_q == ST_DRIVE) ? (ROWS'(1) << row_q) : '0;
        frame_start_d = (state_q == ST_BLANK) && (row_q == '0) && (cnt_q == '0);
        swap_done_d   = swapped_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_BLANK;
            row_q         <= '0;
            step_q        <= '0;
            cnt_q         <= '0;
            pending_q     <= 1'b0;
            front_sel_q   <= 1'b0;
            swapped_q     <= 1'b0;
            mem_q         <= '{default: '0};
            aled_q        <= '1;
            kled_q        <= '0;
            frame_start_q <= 1'b0;
            swap_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            step_q        <= step_d;
            cnt_q         <= cnt_d;
            pending_q     <= pending_d;
            front_sel_q   <= front_sel_d;
            swapped_q     <= swapped_d;
            mem_q         <= mem_d;
            aled_q        <= aled_d;
            kled_q        <= kled_d;
            frame_start_q <= frame_start_d;
            swap_done_q   <= swap_done_d;
        end
    end

    assign aled        = aled_q;
    assign kled_tri    = kled_q;
    assign frame_start = frame_start_q;
    assign swap_done   = swap_done_q;

endmodule

// File: tb/tb_led_matrix_pwm.sv
// ----------------------------------------------------------------------------
// tb_led_matrix_pwm
//
// Directed test of led_matrix_pwm with default parameters (4x4, 4-bit, DWELL
// 64, BLANK 16). Row period = 976 clocks and frame = 3904 clocks. Outputs are
// sampled on the falling edge. Lit-clock counts are accumulated per LED over
// whole rows or frames and compared with hand-computed brightness*DWELL
// values.
// ----------------------------------------------------------------------------
module tb_led_matrix_pwm;

    localparam int ROW_T   = 976;
    localparam int FRAME_T = 3904;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [3:0] wr_data;
    logic       swap_req;
    logic [3:0] aled;
    logic [3:0] kled_tri;
    logic       frame_start;
    logic       swap_done;

    int n_assert = 0;
    int n_fail   = 0;
    int onehot_bad = 0;

    int lit [16];
    int fs_cnt;
    int sd_cnt;
    int a2_cnt;
    int total;
    int off_bad;
    logic fs_second;

    led_matrix_pwm dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .swap_req    (swap_req),
        .aled        (aled),
        .kled_tri    (kled_tri),
        .frame_start (frame_start),
        .swap_done   (swap_done)
    );

    always #5 clk = ~clk;

    // Cathode select must never have two rows on at once.
    always @(negedge clk) begin
        if (!$onehot0(kled_tri)) onehot_bad++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] addr, input logic [3:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        @(negedge clk);
        wr_en   = 1'b0;
        $display("write addr=%0d data=%0d", addr, data);
    endtask

    task automatic swap_pulse();
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
        $display("swap_req pulse");
    endtask

    // Samples n consecutive falling edges starting with the current one and
    // ends on the falling edge after the last sample.
    task automatic measure(input int n);
        for (int i = 0; i < 16; i++) lit[i] = 0;
        fs_cnt = 0;
        sd_cnt = 0;
        a2_cnt = 0;
        for (int k = 0; k < n; k++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    if (kled_tri[r] && !aled[c]) lit[r*4+c]++;
            if (!aled[2]) a2_cnt++;
            if (frame_start) fs_cnt++;
            if (swap_done) sd_cnt++;
            @(negedge clk);
        end
        total = 0;
        for (int i = 0; i < 16; i++) total += lit[i];
        $display("measure %0d clks: lit0=%0d lit1=%0d lit2=%0d lit6=%0d lit7=%0d total=%0d fs=%0d sd=%0d",
                 n, lit[0], lit[1], lit[2], lit[6], lit[7], total, fs_cnt, sd_cnt);
    endtask

    task automatic wait_frame(input int limit);
        int k = 0;
        while (frame_start !== 1'b1 && k < limit) begin
            @(negedge clk);
            k++;
        end
        chk("frame_start_seen", frame_start, 1);
    endtask

    initial begin
        rst      = 1'b1;
        wr_en    = 1'b1;
        wr_addr  = 4'd3;
        wr_data  = 4'd7;
        swap_req = 1'b0;

        // 1. Reset with a write held active; writes during reset are discarded.
        repeat (5) @(negedge clk);
        chk("rst_aled", aled, 4'hF);
        chk("rst_kled", kled_tri, 4'h0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_swap_done", swap_done, 0);
        rst   = 1'b0;
        wr_en = 1'b0;
        @(negedge clk);
        chk("first_frame_start", frame_start, 1);
        chk("first_swap_done", swap_done, 0);
        off_bad = 0;
        fs_second = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (kled_tri != 4'h0 || aled != 4'hF) off_bad++;
            if (k == 1) fs_second = frame_start;
            @(negedge clk);
        end
        chk("blank_all_off", off_bad, 0);
        chk("frame_start_width", fs_second, 0);
        chk("row0_select", kled_tri, 4'b0001);
        chk("row0_dark", aled, 4'hF);
        $display("test1 reset/blank done");

        // 2. LED1 full, LED2 minimum, one swap.
        wr(4'd1, 4'd15);
        wr(4'd2, 4'd1);
        swap_pulse();
        wait_frame(5000);
        chk("t2_swap_done", swap_done, 1);
        measure(ROW_T);
        chk("t2_lit0", lit[0], 0);
        chk("t2_lit1", lit[1], 960);
        chk("t2_lit2", lit[2], 64);
        chk("t2_lit3", lit[3], 0);

        // 3. New back buffer holds only LED6=8 (LED5=0).
        wr(4'd5, 4'd0);
        wr(4'd6, 4'd8);
        swap_pulse();
        wait_frame(5000);
        chk("t3_swap_done", swap_done, 1);
        measure(FRAME_T);
        chk("t3_lit5", lit[5], 0);
        chk("t3_lit6", lit[6], 512);
        chk("t3_total", total, 512);
        chk("t3_aled2_any_row", a2_cnt, 512);
        chk("t3_frame_period", frame_start, 1);
        chk("t3_no_swap", swap_done, 0);

        // 4. Write without swap: display unchanged for 3 frames.
        wr(4'd0, 4'd15);
        wait_frame(5000);
        for (int f = 0; f < 3; f++) begin
            measure(FRAME_T);
            chk("t4_hold_lit0", lit[0], 0);
            chk("t4_hold_sd", sd_cnt, 0);
            chk("t4_hold_fs", fs_cnt, 1);
        end
        measure(1000);
        for (int p = 0; p < 4; p++) begin
            swap_pulse();
            @(negedge clk);
        end
        measure(FRAME_T - 1008);
        chk("t4_pre_boundary_lit0", lit[0], 0);
        chk("t4_pre_boundary_sd", sd_cnt, 0);
        chk("t4_boundary_fs", frame_start, 1);
        chk("t4_boundary_sd", swap_done, 1);
        measure(FRAME_T);
        chk("t4_lit0", lit[0], 960);
        chk("t4_lit1", lit[1], 960);
        chk("t4_lit2", lit[2], 64);
        chk("t4_single_swap", sd_cnt, 1);
        chk("t4_next_no_swap", swap_done, 0);

        // 5. Write and swap_req both in the commit cycle.
        swap_pulse();
        measure(FRAME_T - 3);
        wr_en    = 1'b1;
        wr_addr  = 4'd7;
        wr_data  = 4'd3;
        swap_req = 1'b1;
        @(negedge clk);
        wr_en    = 1'b0;
        swap_req = 1'b0;
        $display("commit-cycle write addr=7 data=3 with swap_req");
        @(negedge clk);
        chk("t5_fs", frame_start, 1);
        chk("t5_sd", swap_done, 1);
        measure(FRAME_T);
        chk("t5_lit7", lit[7], 192);
        chk("t5_lit6", lit[6], 512);
        chk("t5_lit0", lit[0], 0);
        chk("t5_requeued_swap", swap_done, 1);
        measure(ROW_T);
        chk("t5_back_lit0", lit[0], 960);

        // 6. Reset mid-row clears outputs and contents.
        measure(500);
        chk("t6_pre_rst_row1", kled_tri, 4'b0010);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_aled", aled, 4'hF);
        chk("t6_rst_kled", kled_tri, 4'h0);
        @(negedge clk);
        rst = 1'b0;
        $display("mid-row reset released");
        wait_frame(10);
        chk("t6_sd", swap_done, 0);
        measure(FRAME_T);
        chk("t6_all_dark", total, 0);
        chk("onehot_kled", onehot_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
